// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: drives the PLL reset, waits for lock with a timeout,
// qualifies lock over a stability window, then releases the core reset.
// Retries on timeout, recovers from lock loss, and latches a fatal flag
// after the retry allowance is exhausted. Runs entirely on refclk.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STAB = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [7:0]       retry_nx;
    logic [7:0]       loss_nx;
    logic             lock_meta;
    logic             lock_s;
    logic             pll_rst_nx;
    logic             core_rst_nx;
    logic             ready_nx;
    logic             fail_nx;

    // Two-flop synchronizer bringing the asynchronous lock indication into refclk.
    always_ff @(posedge refclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours (lock_s gets the old lock_meta).
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, counter and retry/loss bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        retry_nx = retry_cnt;
        loss_nx  = loss_cnt;

        case (state)
            S_RST: begin
                if (cnt == RST_LAST) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end
            end

            S_WAIT: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_nx = S_STAB;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nx = '0;
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_nx = S_FAIL;
                    end else begin
                        state_nx = S_RST;
                        retry_nx = retry_cnt + 8'd1;
                    end
                end
            end

            S_STAB: begin
                // Any sampled low restarts qualification with a fresh timeout.
                if (!lock_s) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                    retry_nx = 8'd0;
                end
            end

            S_RUN: begin
                // Counter is idle here; hold it so it can never wrap.
                cnt_nx = cnt;
                if (!lock_s) begin
                    state_nx = S_RST;
                    cnt_nx   = '0;
                    if (loss_cnt != 8'hFF) begin
                        loss_nx = loss_cnt + 8'd1;
                    end
                end
            end

            S_FAIL: begin
                // Terminal until rst; the lock input is ignored.
                cnt_nx = cnt;
            end

            default: begin
                state_nx = S_RST;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs register alongside it.
    always_comb begin
        pll_rst_nx  = (state_nx == S_RST) || (state_nx == S_FAIL);
        core_rst_nx = (state_nx != S_RUN);
        ready_nx    = (state_nx == S_RUN);
        fail_nx     = (state_nx == S_FAIL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_RST;
            cnt       <= '0;
            retry_cnt <= 8'd0;
            loss_cnt  <= 8'd0;
            pll_rst   <= 1'b1;
            core_rst  <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            retry_cnt <= retry_nx;
            loss_cnt  <= loss_nx;
            pll_rst   <= pll_rst_nx;
            core_rst  <= core_rst_nx;
            ready     <= ready_nx;
            fail      <= fail_nx;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer. Stimulus pushes hand-computed
// expected output snapshots tagged with a cycle number; a monitor pops and
// compares them when the DUT reaches that cycle. Cycle n is the refclk period
// ending at the n-th edge after rst is released (cycle 0 ends at the first
// edge that samples rst low).
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state_dbg;

    typedef struct packed {
        logic       pll_rst;
        logic       core_rst;
        logic       ready;
        logic       fail;
        logic [7:0] retry;
        logic [7:0] loss;
        logic [2:0] st;
    } obs_t;

    typedef struct {
        int    cyc;
        obs_t  o;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   tick = 0;
    int   t0 = 0;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (20)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .core_rst  (core_rst),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt),
        .state_dbg (state_dbg)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) tick <= tick + 1;

    // Expected snapshots per state, built from the output decode table.
    function automatic obs_t e_rst(int rc, int lc);
        return {1'b1, 1'b1, 1'b0, 1'b0, 8'(rc), 8'(lc), 3'd0};
    endfunction
    function automatic obs_t e_wait(int rc, int lc);
        return {1'b0, 1'b1, 1'b0, 1'b0, 8'(rc), 8'(lc), 3'd1};
    endfunction
    function automatic obs_t e_stab(int rc, int lc);
        return {1'b0, 1'b1, 1'b0, 1'b0, 8'(rc), 8'(lc), 3'd2};
    endfunction
    function automatic obs_t e_run(int rc, int lc);
        return {1'b0, 1'b0, 1'b1, 1'b0, 8'(rc), 8'(lc), 3'd3};
    endfunction
    function automatic obs_t e_fail(int rc, int lc);
        return {1'b1, 1'b1, 1'b0, 1'b1, 8'(rc), 8'(lc), 3'd4};
    endfunction

    task automatic expect_at(input int c, input obs_t o, input string tag);
        exp_t e;
        e.cyc = c;
        e.o   = o;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic check(input exp_t e, input obs_t a, input int cur);
        cmp_cnt++;
        if (e.cyc != cur || a !== e.o) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d (due %0d): got pll_rst=%b core_rst=%b ready=%b fail=%b retry=%0d loss=%0d st=%0d, want pll_rst=%b core_rst=%b ready=%b fail=%b retry=%0d loss=%0d st=%0d",
                     e.tag, cur, e.cyc, a.pll_rst, a.core_rst, a.ready, a.fail, a.retry, a.loss, a.st,
                     e.o.pll_rst, e.o.core_rst, e.o.ready, e.o.fail, e.o.retry, e.o.loss, e.o.st);
        end
    endtask

    // Monitor: sample mid-cycle and retire every snapshot due by now.
    initial begin
        forever begin
            @(negedge refclk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= tick - t0) begin
                check(sb_q.pop_front(),
                      {pll_rst, core_rst, ready, fail, retry_cnt, loss_cnt, state_dbg},
                      tick - t0);
            end
        end
    end

    // Hold rst for two edges, then release; the current period becomes cycle 0.
    task automatic start_run();
        @(posedge refclk);
        #2;
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(posedge refclk);
        #2;
        rst = 1'b0;
        t0  = tick;
    endtask

    // Advance to early in cycle n, where inputs are driven.
    task automatic at(input int n);
        while (tick - t0 < n) begin
            @(posedge refclk);
            #2;
        end
    endtask

    // Wait for the monitor to retire everything, bounded.
    task automatic drain(input string name);
        int b;
        b = 0;
        while (sb_q.size() != 0 && b < 1000) begin
            @(posedge refclk);
            b++;
        end
        if (sb_q.size() != 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL %s drain: %0d snapshots still pending, want 0", name, sb_q.size());
            sb_q.delete();
        end
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Clean bring-up, lock loss in RUN, second loss, then mid-STAB reset.
        start_run();
        expect_at(0,  e_rst(0, 0),  "s1_reset_state");
        expect_at(3,  e_rst(0, 0),  "s1_pll_rst_last_high");
        expect_at(4,  e_wait(0, 0), "s1_pll_rst_low");
        expect_at(12, e_wait(0, 0), "s1_lock_s_seen");
        expect_at(13, e_stab(0, 0), "s1_stab_entry");
        expect_at(20, e_stab(0, 0), "s1_stab_last");
        expect_at(21, e_run(0, 0),  "s1_core_release");
        expect_at(42, e_run(0, 0),  "s4_run_before_loss");
        expect_at(43, e_rst(0, 1),  "s4_loss_reset");
        expect_at(46, e_rst(0, 1),  "s4_rst_last");
        expect_at(47, e_wait(0, 1), "s4_wait");
        expect_at(52, e_wait(0, 1), "s4_relock_seen");
        expect_at(53, e_stab(0, 1), "s4_stab");
        expect_at(60, e_stab(0, 1), "s4_stab_last");
        expect_at(61, e_run(0, 1),  "s4_rerun");
        expect_at(73, e_rst(0, 2),  "s5_second_loss");
        expect_at(77, e_wait(0, 2), "s5_wait");
        expect_at(83, e_stab(0, 2), "s5_stab");
        expect_at(85, e_stab(0, 2), "s5_stab_before_rst");
        expect_at(86, e_rst(0, 0),  "s5_mid_reset");
        expect_at(89, e_rst(0, 0),  "s5_restart_rst");
        expect_at(90, e_wait(0, 0), "s5_restart_wait");
        expect_at(91, e_stab(0, 0), "s5_restart_stab");
        expect_at(98, e_stab(0, 0), "s5_restart_stab_last");
        expect_at(99, e_run(0, 0),  "s5_restart_run");
        at(10); pll_locked = 1'b1;
        at(40); pll_locked = 1'b0;
        at(50); pll_locked = 1'b1;
        at(70); pll_locked = 1'b0;
        at(80); pll_locked = 1'b1;
        at(85); rst = 1'b1;
        at(86); rst = 1'b0;
        drain("s1_s4_s5");

        // Lock bounce during STAB.
        start_run();
        expect_at(0,  e_rst(0, 0),  "s2_reset_state");
        expect_at(12, e_wait(0, 0), "s2_lock_s_seen");
        expect_at(13, e_stab(0, 0), "s2_stab");
        expect_at(15, e_stab(0, 0), "s2_stab_before_drop");
        expect_at(16, e_wait(0, 0), "s2_back_to_wait");
        expect_at(17, e_wait(0, 0), "s2_wait_hold");
        expect_at(18, e_stab(0, 0), "s2_restab");
        expect_at(25, e_stab(0, 0), "s2_stab_last");
        expect_at(26, e_run(0, 0),  "s2_core_release");
        at(10); pll_locked = 1'b1;
        at(13); pll_locked = 1'b0;
        at(15); pll_locked = 1'b1;
        drain("s2");

        // Timeout retries to failure, then late lock ignored.
        start_run();
        expect_at(0,   e_rst(0, 0),  "s3_reset_state");
        expect_at(35,  e_wait(0, 0), "s3_wait_last");
        expect_at(36,  e_rst(1, 0),  "s3_retry1");
        expect_at(39,  e_rst(1, 0),  "s3_retry1_rst_last");
        expect_at(40,  e_wait(1, 0), "s3_retry1_wait");
        expect_at(71,  e_wait(1, 0), "s3_retry1_wait_last");
        expect_at(72,  e_rst(2, 0),  "s3_retry2");
        expect_at(76,  e_wait(2, 0), "s3_retry2_wait");
        expect_at(107, e_wait(2, 0), "s3_final_wait_last");
        expect_at(108, e_fail(2, 0), "s3_fail");
        expect_at(130, e_fail(2, 0), "s3_fail_sticky");
        at(110); pll_locked = 1'b1;
        drain("s3");

        // Lock reaches lock_s on the timeout cycle: lock wins.
        start_run();
        expect_at(0,  e_rst(0, 0),  "s6_reset_state");
        expect_at(34, e_wait(0, 0), "s6_wait");
        expect_at(35, e_wait(0, 0), "s6_timeout_cycle");
        expect_at(36, e_stab(0, 0), "s6_lock_wins");
        expect_at(43, e_stab(0, 0), "s6_stab_last");
        expect_at(44, e_run(0, 0),  "s6_run");
        at(33); pll_locked = 1'b1;
        drain("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
